// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: EX-stage issue/stall sequencer for the multi-cycle divider.
// Optional build macro DIV_ZERO_TRAP_EN: zero divisors skip the divider and raise div_zero_o.
//
//   state | meaning
//   IDLE  | waiting for a DIV/DIVU in EX
//   BUSY  | divider running on latched operands, pipeline stalled
//   DONE  | result presented to EX until the instruction advances
module div_issue_ctrl #(
   parameter int TIMEOUT_CYCLES = 48
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        div_req_i,
   input  logic        div_signed_i,
   input  logic [31:0] reg1_i,
   input  logic [31:0] reg2_i,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic        div_ready_i,
   input  logic [63:0] div_result_i,
   output logic        start_o,
   output logic        annul_o,
   output logic        signed_div_o,
   output logic [31:0] opdata1_o,
   output logic [31:0] opdata2_o,
   output logic        stallreq_o,
   output logic        result_valid_o,
   output logic [63:0] result_o,
   output logic        timeout_o
`ifdef DIV_ZERO_TRAP_EN
   ,
   output logic        div_zero_o
`endif
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic [31:0]       op1_q, op2_q;
   logic              sgn_q;
   logic [63:0]       result_q;
   logic              timeout_q;
   logic [CNT_W-1:0]  wd_cnt;
   logic              issue, zero_trap, wd_hit, capture, expire;

`ifdef DIV_ZERO_TRAP_EN
   logic zero_q;
   assign zero_trap  = (reg2_i == 32'd0);
   assign div_zero_o = zero_q && (state == DONE);
`else
   assign zero_trap  = 1'b0;
`endif

   assign issue  = (state == IDLE) && div_req_i && !flush_i;
   // wd_cnt reads N-1 during the Nth BUSY cycle
   assign wd_hit = (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_nxt      = state;
      start_o        = 1'b0;
      annul_o        = 1'b0;
      stallreq_o     = 1'b0;
      result_valid_o = 1'b0;
      capture        = 1'b0;
      expire         = 1'b0;
      case (state)
         IDLE: begin
            if (issue) begin
               stallreq_o = 1'b1;
               state_nxt  = zero_trap ? DONE : BUSY;
            end
         end
         BUSY: begin
            stallreq_o = 1'b1;
            if (flush_i) begin
               annul_o   = 1'b1;
               state_nxt = IDLE;
            end else if (div_ready_i) begin
               start_o   = 1'b1;
               capture   = 1'b1;
               state_nxt = DONE;
            end else if (wd_hit) begin
               annul_o   = 1'b1;
               expire    = 1'b1;
               state_nxt = DONE;
            end else begin
               start_o   = 1'b1;
            end
         end
         DONE: begin
            result_valid_o = !flush_i;
            // leaving DONE never re-issues, even with div_req_i still high
            if (flush_i || !stall_i)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         op1_q     <= '0;
         op2_q     <= '0;
         sgn_q     <= 1'b0;
         result_q  <= '0;
         timeout_q <= 1'b0;
         wd_cnt    <= '0;
      end else begin
         state <= state_nxt;
         if (issue) begin
            op1_q  <= reg1_i;
            op2_q  <= reg2_i;
            sgn_q  <= div_signed_i;
            wd_cnt <= '0;
         end else if (state == BUSY) begin
            wd_cnt <= wd_cnt + 1'b1;
         end
         if (capture)
            result_q <= div_result_i;
         else if (expire || (issue && zero_trap))
            result_q <= '0;
         if (expire)
            timeout_q <= 1'b1;
      end
   end

`ifdef DIV_ZERO_TRAP_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         zero_q <= 1'b0;
      else if (issue)
         zero_q <= zero_trap;
   end
`endif

   assign signed_div_o = sgn_q;
   assign opdata1_o    = op1_q;
   assign opdata2_o    = op2_q;
   assign result_o     = result_q;
   assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Scoreboard bench for div_issue_ctrl: the bench plays EX and the divider,
// pushes expected {rem, quot} at issue and a monitor pops on each EX advance.
module tb_div_issue_ctrl;

   localparam int TMO = 48;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        div_req_i = 1'b0;
   logic        div_signed_i = 1'b0;
   logic [31:0] reg1_i = '0;
   logic [31:0] reg2_i = '0;
   logic        stall_i = 1'b0;
   logic        flush_i = 1'b0;
   logic        div_ready_i = 1'b0;
   logic [63:0] div_result_i = '0;
   logic        start_o, annul_o, signed_div_o, stallreq_o, result_valid_o, timeout_o;
   logic [31:0] opdata1_o, opdata2_o;
   logic [63:0] result_o;
`ifdef DIV_ZERO_TRAP_EN
   logic        div_zero_o;
`endif

   int          n_vec = 0;
   int          n_err = 0;
   bit          tmo_seen = 1'b0;
   logic [63:0] exp_q[$];

   div_issue_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst),
      .div_req_i(div_req_i), .div_signed_i(div_signed_i),
      .reg1_i(reg1_i), .reg2_i(reg2_i),
      .stall_i(stall_i), .flush_i(flush_i),
      .div_ready_i(div_ready_i), .div_result_i(div_result_i),
      .start_o(start_o), .annul_o(annul_o), .signed_div_o(signed_div_o),
      .opdata1_o(opdata1_o), .opdata2_o(opdata2_o),
      .stallreq_o(stallreq_o), .result_valid_o(result_valid_o),
      .result_o(result_o), .timeout_o(timeout_o)
`ifdef DIV_ZERO_TRAP_EN
      , .div_zero_o(div_zero_o)
`endif
   );

   always #5 clk = ~clk;

   // MIPS semantics: quotient truncates toward zero, remainder takes the dividend's sign
   function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      if (b == 32'd0) return 64'h0;
      if (sgn) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'h0, a});
         sb = longint'({32'h0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   task automatic chk1(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: a result is consumed whenever EX advances with result_valid_o high
   always @(negedge clk) begin
      if (rst && result_valid_o && !stall_i) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_result: got %h expected none at %0t", result_o, $time);
         end else begin
            chk64("result", result_o, exp_q.pop_front());
         end
      end
   end

   // lat: BUSY cycle in which the divider answers (>TMO = never)
   // flush_at: BUSY cycle with flush (0 = none); stalls: DONE stall cycles
   task automatic do_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input int flush_at, input int stalls, input bit flush_done);
      bit flushed, expired, flush_now, ready_now, tmo_now;
      flushed = (flush_at >= 1) && (flush_at <= lat) && (flush_at <= TMO);
      expired = !flushed && (lat > TMO);
      if (!flushed && !flush_done)
         exp_q.push_back(expired ? 64'h0 : ref_div(sgn, a, b));
      @(posedge clk); #1;
      div_req_i = 1'b1; div_signed_i = sgn; reg1_i = a; reg2_i = b;
      @(negedge clk);
      chk1("issue_stallreq", stallreq_o, 1'b1);
      chk1("issue_start", start_o, 1'b0);
      for (int cyc = 1; cyc <= TMO; cyc++) begin
         @(posedge clk); #1;
         reg1_i = $urandom; reg2_i = $urandom; div_signed_i = 1'($urandom);
         flush_now = (cyc == flush_at);
         ready_now = (cyc == lat);
         tmo_now   = (cyc == TMO) && !ready_now && !flush_now;
         flush_i = flush_now;
         div_ready_i = ready_now;
         div_result_i = ready_now ? ref_div(signed_div_o, opdata1_o, opdata2_o) : {$urandom, $urandom};
         @(negedge clk);
         chk1("busy_start", start_o, !flush_now && !tmo_now);
         chk1("busy_annul", annul_o, flush_now || tmo_now);
         chk1("busy_stallreq", stallreq_o, 1'b1);
         chk1("busy_valid", result_valid_o, 1'b0);
         chk32("busy_opdata1", opdata1_o, a);
         chk32("busy_opdata2", opdata2_o, b);
         chk1("busy_signed", signed_div_o, sgn);
         chk1("busy_timeout", timeout_o, tmo_seen);
         if (flush_now || ready_now) break;
      end
      @(posedge clk); #1;
      flush_i = 1'b0; div_ready_i = 1'b0;
      if (flushed) begin
         div_req_i = 1'b0;
         @(negedge clk);
         chk1("post_flush_start", start_o, 1'b0);
         chk1("post_flush_valid", result_valid_o, 1'b0);
         return;
      end
      if (expired) tmo_seen = 1'b1;
      for (int k = 0; k <= stalls; k++) begin
         if (k > 0) begin
            @(posedge clk); #1;
         end
         stall_i = (k < stalls);
         flush_i = flush_done && (k == stalls);
         @(negedge clk);
         chk1("done_start", start_o, 1'b0);
         chk1("done_stallreq", stallreq_o, 1'b0);
         chk1("done_annul", annul_o, 1'b0);
         chk1("done_valid", result_valid_o, !(flush_done && (k == stalls)));
         chk1("done_timeout", timeout_o, tmo_seen);
      end
      @(posedge clk); #1;
      stall_i = 1'b0; flush_i = 1'b0; div_req_i = 1'b0;
      @(negedge clk);
      chk1("idle_start", start_o, 1'b0);
      chk1("idle_valid", result_valid_o, 1'b0);
   endtask

`ifdef DIV_ZERO_TRAP_EN
   task automatic do_zero(input logic [31:0] a);
      exp_q.push_back(64'h0);
      @(posedge clk); #1;
      div_req_i = 1'b1; div_signed_i = 1'b0; reg1_i = a; reg2_i = 32'd0;
      @(negedge clk);
      chk1("zero_issue_stallreq", stallreq_o, 1'b1);
      chk1("zero_issue_start", start_o, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      chk1("zero_done_start", start_o, 1'b0);
      chk1("zero_done_stallreq", stallreq_o, 1'b0);
      chk1("zero_done_flag", div_zero_o, 1'b1);
      chk1("zero_done_valid", result_valid_o, 1'b1);
      @(posedge clk); #1;
      div_req_i = 1'b0;
      @(negedge clk);
      chk1("zero_idle_flag", div_zero_o, 1'b0);
      chk1("zero_idle_start", start_o, 1'b0);
   endtask
`endif

   initial begin
      logic [31:0] ra, rb;
      int          rlat, rfl;
      #3;
      chk1("rst_start", start_o, 1'b0);
      chk1("rst_annul", annul_o, 1'b0);
      chk1("rst_stallreq", stallreq_o, 1'b0);
      chk1("rst_valid", result_valid_o, 1'b0);
      chk1("rst_timeout", timeout_o, 1'b0);
      chk1("rst_signed", signed_div_o, 1'b0);
      chk32("rst_opdata1", opdata1_o, 32'h0);
      chk32("rst_opdata2", opdata2_o, 32'h0);
      chk64("rst_result", result_o, 64'h0);
      @(posedge clk); #1;
      rst = 1'b1;

      do_op(1'b0, 32'd100, 32'd7, 35, 0, 0, 1'b0);
      do_op(1'b1, 32'hFFFF_FFF9, 32'd2, 20, 0, 0, 1'b0);
      do_op(1'b0, 32'd100, 32'd7, 35, 10, 0, 1'b0);
      do_op(1'b0, 32'd9, 32'd3, 5, 0, 0, 1'b0);
      do_op(1'b0, 32'd100, 32'd7, 12, 0, 3, 1'b0);
      do_op(1'b1, 32'd1234, 32'd56, 8, 8, 0, 1'b0);
      do_op(1'b0, 32'd50, 32'd5, 4, 0, 2, 1'b1);
      do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 3, 0, 0, 1'b0);
      do_op(1'b0, 32'd77, 32'd77, 1, 0, 0, 1'b0);
      do_op(1'b0, 32'd1000, 32'd3, TMO - 1, 0, 1, 1'b0);
`ifdef DIV_ZERO_TRAP_EN
      do_zero(32'd5);
`else
      do_op(1'b0, 32'd5, 32'd0, 30, 0, 0, 1'b0);
`endif

      for (int i = 0; i < 30; i++) begin
         ra = $urandom;
         rb = ($urandom_range(3, 0) == 0) ? 32'($urandom_range(9, 1)) : $urandom;
         if ($urandom_range(1, 0) == 1) ra = ra >> $urandom_range(24, 0);
         rlat = $urandom_range(40, 1);
         rfl  = ($urandom_range(3, 0) == 0) ? $urandom_range(rlat, 1) : 0;
         do_op(1'($urandom), ra, rb, rlat, rfl, $urandom_range(3, 0),
               ($urandom_range(9, 0) == 0));
      end

      do_op(1'b0, 32'd100, 32'd7, 1000, 0, 1, 1'b0);
      do_op(1'b0, 32'd9, 32'd3, 6, 0, 0, 1'b0);

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk32("sb_drain", exp_q.size(), 32'd0);
      chk1("timeout_sticky", timeout_o, 1'b1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
